led_fade_ctrl: RTL and testbench
================================

# led_fade_ctrl

Brightness sequencer for the board's RGB LEDs. It holds a per-channel configuration (target level, ramp rate, mode) written over a valid/ready port and steps each channel's output level toward its target once per PWM period. Each `n_high` output drives the `n_high` input of one downstream `pwm` instance directly. All level changes land on a period boundary from an internal counter matched to the pwm `PERIOD`, so a duty cycle never changes mid-period relative to a pwm instance reset at the same time.

## Interface
- `PERIOD`, 32'h10000: PWM period in clocks; must equal the downstream pwm `PERIOD`; ≥ 2.
- `N_CH`, 3: number of LED channels, 1..4.
- `STEP`, 15'd256: level increment per ramp step, ≥ 1.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_valid` in 1: config write request.
- `wr_ready` out 1: write accepted when high with `wr_valid` (combinational).
- `wr_ch` in 2: target channel.
- `wr_target` in 15: target level.
- `wr_rate` in 8: periods per ramp step; 0 means jump.
- `wr_mode` in 1: 0 = ramp-and-hold, 1 = breathe.
- `n_high` out 15×N_CH: per-channel level, channel k at bits [15k+14:15k], registered.
- `at_target` out N_CH: channel level equals target (ramp mode), registered.
- `period_strobe` out 1: high for 1 clk when period counter = `PERIOD`-1.

## Operation
- Period counter `cnt` counts 0..`PERIOD`-1 and wraps. The strobe cycle is `cnt==PERIOD-1`.
- Write path:
  - `wr_ready = !pending[wr_ch]`, or 1 if `wr_ch`≥`N_CH`.
  - Accept fires on `wr_valid && wr_ready`. The fields go to the channel's shadow and set `pending`.
  - Writes to `wr_ch`≥`N_CH` are accepted and dropped.
- On the strobe, per channel:
  - **Pending set:** load the shadow into active config, clear `pending`, clear `div_cnt`, set `dir`=up. No level step this strobe.
  - **Otherwise, rate=0:** level ← target (ramp mode); level ← target / 0 alternating each strobe (breathe).
  - **Otherwise, rate>0:** `div_cnt` increments. At `div_cnt==rate-1` it clears and one step is taken:
    - Ramp mode: level moves toward target by `STEP`, saturating exactly at target with no overshoot. It holds at target.
    - Breathe mode, `dir` up: level ← min(level+`STEP`, target); `dir` ← down when target is reached.
    - Breathe mode, `dir` down: level ← max(level−`STEP`, 0); `dir` ← up when 0 is reached.
    - Breathe with target 0: level stays 0.
- Arithmetic uses 16-bit intermediates and never wraps.
- `at_target[k]` = (level==target) in ramp mode; always 0 in breathe mode.
- `n_high` = level register, updated only on strobe cycles.

## Timing
- Reset values:
  - `cnt`=0, levels=0, targets=0, rates=0, modes=ramp, `dir`=up, `pending`=0, `div_cnt`=0.
  - Outputs: `n_high`=0, `at_target`=all 1, `period_strobe`=0.
- Reset asserted mid-ramp: all state returns to the reset values immediately (asynchronous). Counting restarts at `cnt`=0 after release.
- Write in any cycle, including the strobe cycle: applied at the next strobe strictly after the accept cycle. A write accepted on a strobe cycle waits one full period.
- Write while pending: `wr_ready`=0, no accept. On a strobe cycle `wr_ready` still reflects pre-clear `pending`.
- Latency, rate 0: accept at cycle t, then `n_high` = target in the cycle after the next strobe following t.
- Latency, rate R>0: first step is R strobes after the apply strobe.
- New write mid-ramp: the ramp continues from the current level toward the new target; the level is not reset.

## Structure
- Package `led_ctrl_pkg`:
  - `LEVEL_W`=15, `RATE_W`=8, `CH_W`=2.
  - `led_mode_t` enum {MODE_RAMP, MODE_BREATHE}.
  - Channel config struct {target, rate, mode}.
- Sub-module `led_ramp_ch`, one instance per channel: holds active/shadow config, `pending`, `div_cnt`, `dir` and level. Inputs are the strobe and write-enable.
- Top `led_fade_ctrl` holds the period counter, write decode and output packing.

## Test plan
All scenarios use `PERIOD`=16, `STEP`=4, `N_CH`=3.
- **Reset:** release `rst_n` → `n_high`=0, `at_target`=3'b111, `period_strobe` at cycles 15, 31, …
- **Jump write:** ch0, target=10, rate=0 at cycle 3 → `n_high[0]`=10 from cycle 16, `at_target[0]`=1.
- **Ramp:** ch1, target=10, rate=2 → levels 4, 8, 10 every second strobe after apply, then hold. Ramp back to target 0 → 6, 2, 0.
- **Breathe:** ch2, target=8, rate=1 → 4, 8, 4, 0, 4, … one step per strobe; `at_target[2]`=0.
- **Handshake:**
  - Second write to ch0 before a strobe → `wr_ready`=0 until the strobe clears it.
  - Write on the strobe cycle applies one period later.
  - `wr_ch`=3 is accepted with no effect.
- **Async reset:** assert `rst_n` mid-ramp, asynchronous to `clk` → outputs at reset values before the next edge.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared widths, mode encoding and channel configuration record for the LED fade sequencer.
package led_ctrl_pkg;

    localparam int LEVEL_W = 15;
    localparam int RATE_W  = 8;
    localparam int CH_W    = 2;

    typedef enum logic {
        MODE_RAMP    = 1'b0,
        MODE_BREATHE = 1'b1
    } led_mode_t;

    typedef struct packed {
        logic [LEVEL_W-1:0] target;
        logic [RATE_W-1:0]  rate;
        led_mode_t          mode;
    } led_cfg_t;

    localparam led_cfg_t CFG_RESET = '{target: '0, rate: '0, mode: MODE_RAMP};

endpackage

// File: rtl/led_ramp_ch.sv
// One LED channel: shadow/active configuration and the level stepper that advances once per period strobe.
module led_ramp_ch
    import led_ctrl_pkg::*;
#(
    parameter logic [LEVEL_W-1:0] STEP = 15'd256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               strobe,
    input  logic               wr_en,
    input  led_cfg_t           wr_cfg,
    output logic [LEVEL_W-1:0] level,
    output logic               at_target,
    output logic               pending
);

    led_cfg_t          shadow;
    led_cfg_t          act;
    logic [RATE_W-1:0] div_cnt;
    logic              dir_down;

    led_cfg_t           cfg_nxt;
    logic [LEVEL_W-1:0] level_nxt;
    logic [RATE_W-1:0]  div_nxt;
    logic               dir_nxt;
    logic [LEVEL_W:0]   lvl16;
    logic [LEVEL_W:0]   tgt16;
    logic [LEVEL_W:0]   up_sum;
    logic [LEVEL_W:0]   dn_diff;

    // Next channel state for the coming strobe; 16-bit sums keep the step arithmetic from wrapping.
    always_comb begin
        lvl16     = {1'b0, level};
        tgt16     = {1'b0, act.target};
        up_sum    = lvl16 + {1'b0, STEP};
        dn_diff   = (lvl16 > {1'b0, STEP}) ? (lvl16 - {1'b0, STEP}) : '0;
        cfg_nxt   = act;
        level_nxt = level;
        div_nxt   = div_cnt;
        dir_nxt   = dir_down;
        if (pending) begin
            // New configuration takes effect; only a jump (rate 0) moves the level on this strobe.
            cfg_nxt = shadow;
            div_nxt = '0;
            dir_nxt = 1'b0;
            if (shadow.rate == '0) begin
                level_nxt = shadow.target;
                dir_nxt   = (shadow.mode == MODE_BREATHE);
            end
        end else if (act.rate == '0) begin
            if (act.mode == MODE_RAMP) begin
                level_nxt = act.target;
            end else begin
                level_nxt = dir_down ? '0 : act.target;
                dir_nxt   = !dir_down;
            end
        end else if (div_cnt == act.rate - 8'd1) begin
            div_nxt = '0;
            if (act.mode == MODE_RAMP) begin
                if (lvl16 < tgt16) begin
                    level_nxt = (up_sum >= tgt16) ? act.target : up_sum[LEVEL_W-1:0];
                end else if (lvl16 > tgt16) begin
                    level_nxt = (dn_diff <= tgt16) ? act.target : dn_diff[LEVEL_W-1:0];
                end
            end else if (!dir_down) begin
                if (up_sum >= tgt16) begin
                    level_nxt = act.target;
                    dir_nxt   = 1'b1;
                end else begin
                    level_nxt = up_sum[LEVEL_W-1:0];
                end
            end else begin
                level_nxt = dn_diff[LEVEL_W-1:0];
                if (dn_diff == '0) begin
                    dir_nxt = 1'b0;
                end
            end
        end else begin
            div_nxt = div_cnt + 8'd1;
        end
    end

    // Shadow capture on accept; pending is cleared by the strobe that consumes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= CFG_RESET;
            pending <= 1'b0;
        end else if (wr_en) begin
            shadow  <= wr_cfg;
            pending <= 1'b1;
        end else if (strobe) begin
            pending <= 1'b0;
        end
    end

    // Active state and outputs change only on the period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act       <= CFG_RESET;
            level     <= '0;
            div_cnt   <= '0;
            dir_down  <= 1'b0;
            at_target <= 1'b1;
        end else if (strobe) begin
            act       <= cfg_nxt;
            level     <= level_nxt;
            div_cnt   <= div_nxt;
            dir_down  <= dir_nxt;
            at_target <= (cfg_nxt.mode == MODE_RAMP) && (level_nxt == cfg_nxt.target);
        end
    end

endmodule

// File: rtl/led_fade_ctrl.sv
// LED brightness sequencer top: period counter aligned to the pwm period, write decode, per-channel steppers.
module led_fade_ctrl
    import led_ctrl_pkg::*;
#(
    parameter logic [31:0]        PERIOD = 32'h10000,
    parameter int                 N_CH   = 3,
    parameter logic [LEVEL_W-1:0] STEP   = 15'd256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic [LEVEL_W-1:0]      wr_target,
    input  logic [RATE_W-1:0]       wr_rate,
    input  logic                    wr_mode,
    output logic [LEVEL_W*N_CH-1:0] n_high,
    output logic [N_CH-1:0]         at_target,
    output logic                    period_strobe
);

    localparam int              CNT_W    = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 32'd1);

    logic [CNT_W-1:0] cnt;
    logic             strobe;
    logic [N_CH-1:0]  pending;
    logic [3:0]       pend_all;
    logic             accept;
    led_cfg_t         wr_cfg;

    assign strobe        = (cnt == CNT_LAST);
    assign period_strobe = strobe;

    // Free-running period counter; restarts from 0 after reset so it tracks a pwm reset alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (strobe) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pad pending out to the full channel address range; absent channels always accept.
    always_comb begin
        pend_all            = '0;
        pend_all[N_CH-1:0]  = pending;
    end

    assign wr_ready = (int'(wr_ch) >= N_CH) || !pend_all[wr_ch];
    assign accept   = wr_valid && wr_ready;
    assign wr_cfg   = '{target: wr_target, rate: wr_rate, mode: led_mode_t'(wr_mode)};

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        led_ramp_ch #(
            .STEP (STEP)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .strobe    (strobe),
            .wr_en     (accept && (wr_ch == CH_W'(k))),
            .wr_cfg    (wr_cfg),
            .level     (n_high[LEVEL_W*k +: LEVEL_W]),
            .at_target (at_target[k]),
            .pending   (pending[k])
        );
    end

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Self-checking bench for led_fade_ctrl: directed scenarios plus random writes against a strobe-level model.
module tb_led_fade_ctrl;

    localparam int PERIOD = 16;
    localparam int N_CH   = 3;
    localparam int STEP   = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 wr_valid = 1'b0;
    logic                 wr_ready;
    logic [1:0]           wr_ch = '0;
    logic [14:0]          wr_target = '0;
    logic [7:0]           wr_rate = '0;
    logic                 wr_mode = 1'b0;
    logic [15*N_CH-1:0]   n_high;
    logic [N_CH-1:0]      at_target;
    logic                 period_strobe;

    led_fade_ctrl #(
        .PERIOD (32'(PERIOD)),
        .N_CH   (N_CH),
        .STEP   (15'(STEP))
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_ch         (wr_ch),
        .wr_target     (wr_target),
        .wr_rate       (wr_rate),
        .wr_mode       (wr_mode),
        .n_high        (n_high),
        .at_target     (at_target),
        .period_strobe (period_strobe)
    );

    always #5 clk = ~clk;

    // Reference model: levels per channel, strobes counted since the config was applied.
    int m_cnt;
    int lvl[N_CH], tgt[N_CH], rate[N_CH], mode[N_CH], down[N_CH], since[N_CH], pend[N_CH];
    int sh_tgt[N_CH], sh_rate[N_CH], sh_mode[N_CH];
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        for (int k = 0; k < N_CH; k++) begin
            lvl[k] = 0; tgt[k] = 0; rate[k] = 0; mode[k] = 0; down[k] = 0;
            since[k] = 0; pend[k] = 0; sh_tgt[k] = 0; sh_rate[k] = 0; sh_mode[k] = 0;
        end
    endtask

    function automatic int model_ready(input int ch);
        return (ch >= N_CH) ? 1 : int'(pend[ch] == 0);
    endfunction

    task automatic model_strobe();
        for (int k = 0; k < N_CH; k++) begin
            if (pend[k] != 0) begin
                tgt[k] = sh_tgt[k]; rate[k] = sh_rate[k]; mode[k] = sh_mode[k];
                pend[k] = 0; since[k] = 0; down[k] = 0;
                if (rate[k] == 0) begin
                    lvl[k] = tgt[k];
                    down[k] = mode[k];
                end
            end else if (rate[k] == 0) begin
                if (mode[k] == 0) lvl[k] = tgt[k];
                else begin
                    lvl[k] = (down[k] != 0) ? 0 : tgt[k];
                    down[k] = (down[k] == 0);
                end
            end else begin
                since[k]++;
                if (since[k] % rate[k] == 0) begin
                    if (mode[k] == 0) begin
                        if (lvl[k] < tgt[k]) lvl[k] = (lvl[k] + STEP > tgt[k]) ? tgt[k] : lvl[k] + STEP;
                        else if (lvl[k] > tgt[k]) lvl[k] = (lvl[k] - STEP < tgt[k]) ? tgt[k] : lvl[k] - STEP;
                    end else if (down[k] == 0) begin
                        lvl[k] = (lvl[k] + STEP > tgt[k]) ? tgt[k] : lvl[k] + STEP;
                        if (lvl[k] == tgt[k]) down[k] = 1;
                    end else begin
                        lvl[k] = (lvl[k] - STEP < 0) ? 0 : lvl[k] - STEP;
                        if (lvl[k] == 0) down[k] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("period_strobe", int'(period_strobe), int'(m_cnt == PERIOD - 1));
        check("wr_ready", int'(wr_ready), model_ready(int'(wr_ch)));
        for (int k = 0; k < N_CH; k++) begin
            check($sformatf("n_high[%0d]", k), int'(n_high[15*k +: 15]), lvl[k]);
            check($sformatf("at_target[%0d]", k), int'(at_target[k]),
                  int'(mode[k] == 0 && lvl[k] == tgt[k]));
        end
    endtask

    // One clock: drive, check at the falling edge, advance the model on the rising edge.
    task automatic run_cycle(input logic v, input int ch, input int tg, input int rt, input int md);
        logic acc;
        wr_valid  = v;
        wr_ch     = 2'(ch);
        wr_target = 15'(tg);
        wr_rate   = 8'(rt);
        wr_mode   = 1'(md);
        @(negedge clk);
        check_outputs();
        acc = v && (model_ready(ch) != 0);
        @(posedge clk);
        if (m_cnt == PERIOD - 1) model_strobe();
        if (acc && ch < N_CH) begin
            pend[ch] = 1; sh_tgt[ch] = tg; sh_rate[ch] = rt; sh_mode[ch] = md;
        end
        m_cnt = (m_cnt + 1) % PERIOD;
        #1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst n_high", int'(n_high), 0);
        check("rst at_target", int'(at_target), 7);
        check("rst strobe", int'(period_strobe), 0);
        rst_n = 1'b1;

        // Directed: jump, ramp up/down, breathe, busy channel, strobe-cycle write, dropped channel.
        for (int cyc = 0; cyc < 260; cyc++) begin
            case (cyc)
                3:       run_cycle(1'b1, 0, 10, 0, 0);
                5:       run_cycle(1'b1, 0, 20, 0, 0);
                20:      run_cycle(1'b1, 1, 10, 2, 0);
                31:      run_cycle(1'b1, 2, 8, 1, 1);
                40:      run_cycle(1'b1, 3, 30, 1, 0);
                140:     run_cycle(1'b1, 1, 0, 2, 0);
                default: run_cycle(1'b0, 0, 0, 0, 0);
            endcase
            case (cyc + 1)
                15:  check("jump before strobe", int'(n_high[14:0]), 0);
                16:  check("jump level", int'(n_high[14:0]), 10);
                64:  begin
                         check("ramp step1", int'(n_high[29:15]), 4);
                         check("breathe step1", int'(n_high[44:30]), 4);
                     end
                96:  begin
                         check("ramp step2", int'(n_high[29:15]), 8);
                         check("breathe down", int'(n_high[44:30]), 4);
                         check("breathe at_target", int'(at_target[2]), 0);
                     end
                128: check("ramp hold", int'(n_high[29:15]), 10);
                192: check("ramp down1", int'(n_high[29:15]), 6);
                256: check("ramp down3", int'(n_high[29:15]), 0);
                default: ;
            endcase
        end

        // Random writes against the model.
        for (int i = 0; i < 800; i++) begin
            run_cycle(($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 24)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 1)));
        end

        // Asynchronous reset between clock edges.
        wr_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async n_high", int'(n_high), 0);
        check("async at_target", int'(at_target), 7);
        check("async strobe", int'(period_strobe), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            run_cycle(($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 40)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
